stream_to_axi_wr: RTL and testbench

STREAM_TO_AXI_WR -- requirements
Module: stream_to_axi_wr

---
 rtl/stream_to_axi_pkg.sv | 48 ++++
 rtl/stream_to_axi_wr_reg_slice.sv | 33 +++
 rtl/stream_to_axi_wr.sv | 255 +++++++++++++++++++++++++
 tb/tb_stream_to_axi_wr.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_to_axi_pkg.sv
// Shared definitions for the stream-to-AXI4 write bridge.
//   - Header beat field offsets/widths (AW fields packed into the first beat)
//   - Bridge FSM state enumeration
//   - Response beat layout and a helper that assembles one response beat
package stream_to_axi_pkg;

    // Header beat layout
    localparam int unsigned HDR_ADDR_LSB  = 0;
    localparam int unsigned HDR_ADDR_W    = 32;
    localparam int unsigned HDR_LEN_LSB   = 32;
    localparam int unsigned HDR_LEN_W     = 8;
    localparam int unsigned HDR_SIZE_LSB  = 40;
    localparam int unsigned HDR_SIZE_W    = 3;
    localparam int unsigned HDR_BURST_LSB = 43;
    localparam int unsigned HDR_BURST_W   = 2;
    localparam int unsigned HDR_ID_LSB    = 45;

    // Response beat layout: {1'b0, frame_err_of_txn, bresp, bid}
    localparam int unsigned RSP_W        = 8;
    localparam int unsigned RSP_ID_LSB   = 0;
    localparam int unsigned RSP_ID_W     = 4;
    localparam int unsigned RSP_RESP_LSB = 4;
    localparam int unsigned RSP_RESP_W   = 2;
    localparam int unsigned RSP_ERR_BIT  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_PAD,
        ST_DRAIN,
        ST_B
    } state_t;

    function automatic logic [RSP_W-1:0] rsp_beat(
        input logic                  err,
        input logic [RSP_RESP_W-1:0] resp,
        input logic [RSP_ID_W-1:0]   id
    );
        logic [RSP_W-1:0] b;
        b                             = '0;
        b[RSP_ID_LSB +: RSP_ID_W]     = id;
        b[RSP_RESP_LSB +: RSP_RESP_W] = resp;
        b[RSP_ERR_BIT]                = err;
        return b;
    endfunction

endpackage

// File: rtl/stream_to_axi_wr_reg_slice.sv
// axis_reg_slice: single-stage registered valid/ready slice.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (empties the slice)
//   in_data/valid/ready   upstream side; in_ready = !out_valid || out_ready
//   out_data/valid/ready  downstream side; out_data held stable while stalled
module axis_reg_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_to_axi_wr.sv
// stream_to_axi_wr: converts a command stream (one header beat followed by
// data beats) into a single AXI4 write burst, one transaction at a time.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             command stream in (header, then data beats)
//   m_axi_aw*            AXI4 write address channel
//   m_axi_w*             AXI4 write data channel (registered via axis_reg_slice)
//   m_axi_b*             AXI4 write response channel
//   m_axis_*             response stream out (only with STREAM_TO_AXI_WR_RESP_EN)
//   frame_err            sticky flag: stream tlast disagreed with AWLEN
// Build option: define STREAM_TO_AXI_WR_RESP_EN to forward each B response as
// a one-beat response stream; otherwise the B response is consumed silently.
module stream_to_axi_wr
    import stream_to_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
`ifdef STREAM_TO_AXI_WR_RESP_EN
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
`endif
    output logic                frame_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SL_W   = DATA_W + STRB_W + 1;

    state_t              state;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [7:0]          awlen_q;
    logic [2:0]          awsize_q;
    logic [1:0]          awburst_q;
    logic [ID_W-1:0]     awid_q;
    logic                awvalid_q;
    logic [7:0]          cnt;
    logic                frame_err_q;
    logic                txn_err;
    logic                drain_done;
    logic                b_done;

    logic                sl_in_valid;
    logic                sl_in_ready;
    logic [SL_W-1:0]     sl_in_data;
    logic [SL_W-1:0]     sl_out_data;
    logic                sl_out_valid;

    logic                beat_last;
    logic                tready_int;
    logic                bready_int;
    logic                b_hs;
    logic                drain_fin;
    logic                resp_fin;
    logic                txn_fin;

`ifdef STREAM_TO_AXI_WR_RESP_EN
    logic                rsp_valid;
    logic [RSP_W-1:0]    rsp_data;
`endif

    assign beat_last = (cnt == awlen_q);

    always_comb begin
        tready_int  = 1'b0;
        bready_int  = 1'b0;
        sl_in_valid = 1'b0;
        sl_in_data  = {s_axis_tdata, s_axis_tkeep, beat_last};
        case (state)
            ST_IDLE:  tready_int = 1'b1;
            ST_W: begin
                tready_int  = sl_in_ready;
                sl_in_valid = s_axis_tvalid;
            end
            ST_PAD: begin
                sl_in_valid = 1'b1;
                sl_in_data  = {{(DATA_W + STRB_W){1'b0}}, beat_last};
            end
            ST_DRAIN: tready_int = !drain_done;
            default:  tready_int = 1'b0;
        endcase

        // B may be accepted while DRAIN is still discarding stream beats
        if (state == ST_B || state == ST_DRAIN) begin
`ifdef STREAM_TO_AXI_WR_RESP_EN
            bready_int = !b_done && (m_axis_tready || !rsp_valid);
`else
            bready_int = !b_done;
`endif
        end
        b_hs      = m_axi_bvalid && bready_int;
        drain_fin = drain_done || (state == ST_DRAIN && s_axis_tvalid && s_axis_tlast);
`ifdef STREAM_TO_AXI_WR_RESP_EN
        resp_fin  = b_done && (!rsp_valid || m_axis_tready);
`else
        resp_fin  = b_done || b_hs;
`endif
        txn_fin   = drain_fin && resp_fin;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awid_q      <= '0;
            awvalid_q   <= 1'b0;
            cnt         <= '0;
            frame_err_q <= 1'b0;
            txn_err     <= 1'b0;
            drain_done  <= 1'b0;
            b_done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        awaddr_q  <= ADDR_W'(s_axis_tdata[HDR_ADDR_LSB +: HDR_ADDR_W]);
                        awlen_q   <= s_axis_tdata[HDR_LEN_LSB +: HDR_LEN_W];
                        awsize_q  <= s_axis_tdata[HDR_SIZE_LSB +: HDR_SIZE_W];
                        awburst_q <= s_axis_tdata[HDR_BURST_LSB +: HDR_BURST_W];
                        awid_q    <= s_axis_tdata[HDR_ID_LSB +: ID_W];
                        awvalid_q <= 1'b1;
                        cnt       <= '0;
                        txn_err   <= 1'b0;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (s_axis_tvalid && sl_in_ready) begin
                        if (beat_last) begin
                            drain_done <= s_axis_tlast;
                            b_done     <= 1'b0;
                            if (s_axis_tlast) begin
                                state <= ST_B;
                            end else begin
                                frame_err_q <= 1'b1;
                                txn_err     <= 1'b1;
                                state       <= ST_DRAIN;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                            if (s_axis_tlast) begin
                                frame_err_q <= 1'b1;
                                txn_err     <= 1'b1;
                                state       <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (sl_in_ready) begin
                        if (beat_last) begin
                            drain_done <= 1'b1;
                            b_done     <= 1'b0;
                            state      <= ST_B;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN, ST_B: begin
                    if (drain_fin) drain_done <= 1'b1;
                    if (b_hs)      b_done     <= 1'b1;
                    if (txn_fin)        state <= ST_IDLE;
                    else if (drain_fin) state <= ST_B;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STREAM_TO_AXI_WR_RESP_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (b_hs) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rsp_beat(txn_err, m_axi_bresp, RSP_ID_W'(m_axi_bid));
        end else if (m_axis_tready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = rsp_data;
    assign m_axis_tvalid = aresetn && rsp_valid;
    assign m_axis_tlast  = 1'b1;
`else
    logic unused_b;
    assign unused_b = ^{m_axi_bid, m_axi_bresp, txn_err};
`endif

    axis_reg_slice #(
        .W (SL_W)
    ) u_w_slice (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   (sl_in_data),
        .in_valid  (sl_in_valid),
        .in_ready  (sl_in_ready),
        .out_data  (sl_out_data),
        .out_valid (sl_out_valid),
        .out_ready (m_axi_wready)
    );

    // Handshake outputs are forced low while reset is held, before the edge
    assign s_axis_tready = aresetn && tready_int;
    assign m_axi_awvalid = aresetn && awvalid_q;
    assign m_axi_wvalid  = aresetn && sl_out_valid;
    assign m_axi_bready  = aresetn && bready_int;

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = awsize_q;
    assign m_axi_awburst = awburst_q;
    assign m_axi_awid    = awid_q;
    assign m_axi_wdata   = sl_out_data[SL_W-1 -: DATA_W];
    assign m_axi_wstrb   = sl_out_data[STRB_W:1];
    assign m_axi_wlast   = sl_out_data[0];
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_stream_to_axi_wr.sv
// Self-checking bench for stream_to_axi_wr: directed vector table, random
// transactions against a transaction-level model, and hand-written reset and
// response-forwarding sequences (the latter with STREAM_TO_AXI_WR_RESP_EN).
module tb_stream_to_axi_wr;

    logic        aclk;
    logic        aresetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        frame_err;
`ifdef STREAM_TO_AXI_WR_RESP_EN
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
`endif

    stream_to_axi_wr #(
        .ADDR_W (32),
        .DATA_W (64),
        .ID_W   (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axi_awaddr  (awaddr),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_awburst (awburst),
        .m_axi_awid    (awid),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bid     (bid),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
`ifdef STREAM_TO_AXI_WR_RESP_EN
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
`endif
        .frame_err     (frame_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned vecs = 0;
    int unsigned errs = 0;
    bit          exp_err;
    int unsigned wr_mode = 0;
    bit          aw_rand = 0;
    logic [1:0]  resp_cfg = 2'b00;

    // Monitor state (written only by the monitor process)
    logic [48:0] aw_got[$];
    logic [72:0] w_got[$];
    int unsigned aw_cnt = 0, b_cnt = 0, wl_cnt = 0, viol = 0;
    bit          bhs = 0, w_pend = 0, aw_pend = 0;
    logic [72:0] w_hold;
    logic [48:0] aw_hold;
    logic [3:0]  last_awid = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Handshake monitor, sampled mid-cycle
    always @(negedge aclk) begin
        if (!aresetn) begin
            aw_got.delete();
            w_got.delete();
            aw_cnt  = 0;
            b_cnt   = 0;
            wl_cnt  = 0;
            bhs     = 0;
            w_pend  = 0;
            aw_pend = 0;
        end else begin
            if (w_pend && (!wvalid || {wdata, wstrb, wlast} != w_hold)) viol++;
            if (aw_pend && (!awvalid || {awaddr, awlen, awsize, awburst, awid} != aw_hold)) viol++;
            if (wvalid && aw_cnt != b_cnt + 1) viol++;
            w_pend  = wvalid && !wready;
            w_hold  = {wdata, wstrb, wlast};
            aw_pend = awvalid && !awready;
            aw_hold = {awaddr, awlen, awsize, awburst, awid};
            if (wvalid && wready) begin
                w_got.push_back({wdata, wstrb, wlast});
                if (wlast) wl_cnt++;
            end
            if (awvalid && awready) begin
                aw_got.push_back({awaddr, awlen, awsize, awburst, awid});
                last_awid = awid;
                aw_cnt++;
            end
            bhs = bvalid && bready;
            if (bhs) b_cnt++;
        end
    end

    // Slave ready drivers
    int unsigned cyc3 = 0;
    always @(posedge aclk) begin
        #1;
        cyc3++;
        case (wr_mode)
            0:       wready = 1'b1;
            1:       wready = (cyc3 % 3 == 0);
            default: wready = 1'($urandom_range(0, 1));
        endcase
        awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // B responder: one response per wlast handshake, a couple of cycles later
    int unsigned b_issued = 0, bdly = 0;
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            bvalid   = 1'b0;
            b_issued = 0;
            bdly     = 0;
        end else if (bvalid) begin
            if (bhs) bvalid = 1'b0;
        end else if (wl_cnt > b_issued) begin
            if (bdly >= 2) begin
                bvalid = 1'b1;
                bid    = last_awid;
                bresp  = resp_cfg;
                b_issued++;
                bdly   = 0;
            end else begin
                bdly++;
            end
        end
    end

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int unsigned n = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("stream_handshake", s_tready, 1'b1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        exp_err  = 1'b0;
    endtask

    // Model: stream beats 0..tpos are real; W carries len+1 beats, real up to
    // min(tpos,len) then zero-filled; wlast only on beat len; error iff tpos!=len.
    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len,
                           input logic [7:0] tpos, input logic [3:0] id,
                           output int unsigned pad_got);
        logic [63:0] dq[$];
        logic [7:0]  kq[$];
        int unsigned wb, ab, bb, n;
        logic [72:0] expw, gotw;
        wb = w_got.size();
        ab = aw_got.size();
        bb = b_cnt;
        push_beat({15'd0, id, 2'd1, 3'd3, len, addr}, 8'($urandom), 1'($urandom));
        for (int i = 0; i <= int'(tpos); i++) begin
            dq.push_back({$urandom, $urandom});
            kq.push_back(8'($urandom_range(1, 255)));
            push_beat(dq[i], kq[i], i == int'(tpos));
        end
        n = 0;
        while (b_cnt == bb && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("b_response_seen", b_cnt != bb, 1'b1);
        @(posedge aclk);
        #1;
        check("aw_count", aw_got.size() - ab, 1);
        if (aw_got.size() > ab)
            check("aw_fields", aw_got[ab], {addr, len, 3'd3, 2'd1, id});
        check("w_count", w_got.size() - wb, int'(len) + 1);
        pad_got = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i <= int'(tpos)) expw = {dq[i], kq[i], i == int'(len)};
            else                 expw = {64'd0, 8'd0, i == int'(len)};
            if (wb + i < w_got.size()) gotw = w_got[wb + i];
            else                       gotw = 'x;
            check("w_beat", gotw, expw);
            if (gotw[8:1] == 8'd0) pad_got++;
        end
        exp_err = exp_err | (tpos != len);
        check("frame_err", frame_err, exp_err);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  tpos;
        logic [3:0]  id;
        int unsigned wmode;
        bit          rst;
        bit          exp_err;
        int unsigned exp_pad;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[7];
        int unsigned pad, bad;
        tbl[0] = '{32'h1000, 8'd3, 8'd3, 4'd5, 0, 1'b1, 1'b0, 0};
        tbl[1] = '{32'h2000, 8'd3, 8'd1, 4'd2, 0, 1'b1, 1'b1, 2};
        tbl[2] = '{32'h3000, 8'd1, 8'd3, 4'd7, 0, 1'b1, 1'b1, 0};
        tbl[3] = '{32'h4000, 8'd0, 8'd0, 4'd1, 2, 1'b0, 1'b1, 0};
        tbl[4] = '{32'h5000, 8'd7, 8'd7, 4'd3, 1, 1'b1, 1'b0, 0};
        tbl[5] = '{32'h6000, 8'd0, 8'd2, 4'd9, 2, 1'b1, 1'b1, 0};
        tbl[6] = '{32'h7000, 8'd5, 8'd0, 4'd4, 2, 1'b1, 1'b1, 5};

        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        bvalid   = 1'b0;
        bid      = '0;
        bresp    = '0;
        exp_err  = 1'b0;
`ifdef STREAM_TO_AXI_WR_RESP_EN
        m_tready = 1'b1;
`endif
        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
`ifdef STREAM_TO_AXI_WR_RESP_EN
        check("rst_m_tvalid", m_tvalid, 1'b0);
`endif
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_s_tready", s_tready, 1'b1);
        @(posedge aclk);
        #1;

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            if (tbl[v].rst) do_reset();
            wr_mode = tbl[v].wmode;
            run_txn(tbl[v].addr, tbl[v].len, tbl[v].tpos, tbl[v].id, pad);
            check("tbl_pad", pad, tbl[v].exp_pad);
            check("tbl_frame_err", frame_err, tbl[v].exp_err);
        end

        // Random transactions
        do_reset();
        aw_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            logic [7:0] len, tpos;
            len      = 8'($urandom_range(0, 15));
            tpos     = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, int'(len) + 3)) : len;
            wr_mode  = $urandom_range(0, 2);
            resp_cfg = 2'($urandom);
            run_txn({$urandom_range(0, 65535), 16'h0}, len, tpos, 4'($urandom), pad);
        end
        aw_rand = 1'b0;
        check("protocol_violations", viol, 0);

        // Reset in the middle of a burst
        wr_mode = 0;
        run_txn(32'h8000, 8'd1, 8'd0, 4'd6, pad);
        push_beat({15'd0, 4'd3, 2'd1, 3'd3, 8'd7, 32'h9000}, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) push_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_wvalid", wvalid, 1'b0);
        check("midrst_awvalid", awvalid, 1'b0);
        check("midrst_s_tready", s_tready, 1'b0);
        check("midrst_bready", bready, 1'b0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("midrst_frame_err", frame_err, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_err = 1'b0;
        @(negedge aclk);
        check("midrst_idle_tready", s_tready, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (wvalid || awvalid) bad++;
        end
        check("midrst_no_beats", bad, 0);
        @(posedge aclk);
        #1;
        run_txn(32'hA000, 8'd2, 8'd2, 4'd8, pad);

`ifdef STREAM_TO_AXI_WR_RESP_EN
        // Response forwarding with a stalled response stream
        do_reset();
        resp_cfg = 2'b10;
        m_tready = 1'b0;
        run_txn(32'h1000, 8'd0, 8'd0, 4'd5, pad);
        @(negedge aclk);
        check("resp_tvalid", m_tvalid, 1'b1);
        check("resp_tdata", m_tdata, 8'h25);
        check("resp_tlast", m_tlast, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (bready || !m_tvalid || s_tready) bad++;
        end
        check("resp_hold", bad, 0);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("resp_done_tvalid", m_tvalid, 1'b0);
        check("resp_done_idle", s_tready, 1'b1);
`endif

        check("protocol_violations_end", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
